// File: rtl/immunit_pipe_if.sv
// Handshake bundle for the pipelined immediate unit.
// master drives requests and OutReady; slave is the unit itself.
interface immunit_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             InValid;
  logic             InReady;
  logic [24:0]      ImmInput;
  logic [2:0]       ImmSrc;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [XLEN-1:0]  ImmExt;
  logic [TAG_W-1:0] OutTag;
  logic             IllegalSrc;

  modport master (
    output InValid, ImmInput, ImmSrc, InTag, OutReady,
    input  InReady, OutValid, ImmExt, OutTag, IllegalSrc
  );

  modport slave (
    input  InValid, ImmInput, ImmSrc, InTag, OutReady,
    output InReady, OutValid, ImmExt, OutTag, IllegalSrc
  );
endinterface

// File: rtl/immunit_pipe.sv
// Pipelined immediate extender with 2-entry skid buffer,
// sideband tag and saturating illegal-select counter.
module immunit_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  immunit_pipe_if.slave    bus,
  output logic [ERR_W-1:0] ErrCnt
);

  logic [24:0]      i;
  logic [2:0]       src;
  logic [XLEN-1:0]  decImm;
  logic             decIll;
  logic             accept;
  logic             drain;

  logic             oValid;
  logic [XLEN-1:0]  oImm;
  logic [TAG_W-1:0] oTag;
  logic             oIll;
  logic             sValid;
  logic [XLEN-1:0]  sImm;
  logic [TAG_W-1:0] sTag;
  logic             sIll;

  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v
  );
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zx(
    input logic [31:0] v
  );
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v;
    return r;
  endfunction

  assign i   = bus.ImmInput;
  assign src = bus.ImmSrc;

  always_comb begin
    decImm = '0;
    decIll = 1'b0;
    unique case (1'b1)
      (src == 3'b000):
        decImm = sx({{20{i[24]}}, i[24:13]});
      (src == 3'b001):
        decImm = sx({{20{i[24]}}, i[24:18], i[4:0]});
      (src == 3'b101):
        decImm = sx({{19{i[24]}}, i[24], i[0],
                     i[23:18], i[4:1], 1'b0});
      (src == 3'b010):
        decImm = sx({i[24:5], 12'b0});
      (src == 3'b110):
        decImm = sx({{11{i[24]}}, i[24], i[12:5],
                     i[13], i[23:14], 1'b0});
      // bit 18 only belongs to the shift amount on RV64
      (src == 3'b011):
        decImm = zx({26'b0,
                     (XLEN == 64) ? i[18] : 1'b0,
                     i[17:13]});
      (src == 3'b100):
        decImm = zx({27'b0, i[12:8]});
      default:
        decIll = 1'b1;
    endcase
  end

  assign bus.InReady = !sValid && !rst;
  assign accept      = bus.InValid && bus.InReady;
  assign drain       = oValid && bus.OutReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      oValid <= 1'b0;
      oImm   <= '0;
      oTag   <= '0;
      oIll   <= 1'b0;
      sValid <= 1'b0;
      sImm   <= '0;
      sTag   <= '0;
      sIll   <= 1'b0;
      ErrCnt <= '0;
    end else begin
      if (!oValid || drain) begin
        if (sValid) begin
          oValid <= 1'b1;
          oImm   <= sImm;
          oTag   <= sTag;
          oIll   <= sIll;
          sValid <= 1'b0;
        end else if (accept) begin
          oValid <= 1'b1;
          oImm   <= decImm;
          oTag   <= bus.InTag;
          oIll   <= decIll;
        end else begin
          oValid <= 1'b0;
        end
      end else if (accept) begin
        sValid <= 1'b1;
        sImm   <= decImm;
        sTag   <= bus.InTag;
        sIll   <= decIll;
      end
      if (accept && decIll &&
          (ErrCnt != {ERR_W{1'b1}}))
        ErrCnt <= ErrCnt + ERR_W'(1);
    end
  end

  assign bus.OutValid   = oValid;
  assign bus.ImmExt     = oImm;
  assign bus.OutTag     = oTag;
  assign bus.IllegalSrc = oIll;

endmodule

// File: tb/tb_immunit_pipe.sv
// Bench for immunit_pipe: vector table, hand-written corner
// sequences and random traffic against a queue model.
module tb_immunit_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  immunit_pipe_if #(.XLEN(32), .TAG_W(5)) b32();
  immunit_pipe_if #(.XLEN(64), .TAG_W(5)) b64();
  logic [7:0] err32;
  logic [7:0] err64;

  immunit_pipe #(.XLEN(32), .TAG_W(5), .ERR_W(8)) d32 (
    .clk(clk), .rst(rst), .bus(b32), .ErrCnt(err32)
  );
  immunit_pipe #(.XLEN(64), .TAG_W(5), .ERR_W(8)) d64 (
    .clk(clk), .rst(rst), .bus(b64), .ErrCnt(err64)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is64;
    logic [24:0] imm;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [63:0] exp;
    bit          ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    bit          ill;
  } item_t;

  item_t q32[$];
  item_t q64[$];
  int    m32 = 0;
  int    m64 = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference immediates in terms of real instruction bits
  function automatic logic [63:0] refImm(
    input logic [24:0] ii, input logic [2:0] s, input bit is64
  );
    logic [31:0] ins;
    longint      v;
    ins = {ii, 7'b0};
    case (s)
      3'b000: v = $signed(ins[31:20]);
      3'b001: v = $signed({ins[31:25], ins[11:7]});
      3'b101: v = $signed({ins[31], ins[7], ins[30:25],
                           ins[11:8], 1'b0});
      3'b010: v = $signed({ins[31:12], 12'b0});
      3'b110: v = $signed({ins[31], ins[19:12], ins[20],
                           ins[30:21], 1'b0});
      3'b011: v = is64 ? longint'(ins[25:20])
                       : longint'(ins[24:20]);
      3'b100: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (!is64) v = v & 64'hFFFF_FFFF;
    return 64'(v);
  endfunction

  task automatic drv32(input logic v, input logic [2:0] s,
                       input logic [24:0] ii,
                       input logic [4:0] t, input logic r);
    b32.InValid  = v;
    b32.ImmSrc   = s;
    b32.ImmInput = ii;
    b32.InTag    = t;
    b32.OutReady = r;
  endtask

  task automatic drv64(input logic v, input logic [2:0] s,
                       input logic [24:0] ii,
                       input logic [4:0] t, input logic r);
    b64.InValid  = v;
    b64.ImmSrc   = s;
    b64.ImmInput = ii;
    b64.InTag    = t;
    b64.OutReady = r;
  endtask

  task automatic pulseRst();
    @(negedge clk);
    rst = 1'b1;
    drv32(0, 0, 0, 0, 0);
    drv64(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic observe(input bit is64, input string nm);
    item_t       f;
    int          sz;
    int          m;
    logic        ov, ir, il;
    logic [63:0] im;
    logic [4:0]  tg;
    logic [7:0]  e;
    f = '{64'd0, 5'd0, 1'b0};
    if (is64) begin
      sz = q64.size(); m = m64; e = err64;
      ov = b64.OutValid; ir = b64.InReady;
      im = b64.ImmExt; tg = b64.OutTag; il = b64.IllegalSrc;
      if (sz > 0) f = q64[0];
    end else begin
      sz = q32.size(); m = m32; e = err32;
      ov = b32.OutValid; ir = b32.InReady;
      im = 64'(b32.ImmExt); tg = b32.OutTag;
      il = b32.IllegalSrc;
      if (sz > 0) f = q32[0];
    end
    check({nm, ".outValid"}, 64'(ov), 64'(sz != 0));
    check({nm, ".inReady"}, 64'(ir), 64'(sz < 2));
    check({nm, ".errCnt"}, 64'(e), 64'(m));
    if (sz > 0) begin
      check({nm, ".immExt"}, im, f.imm);
      check({nm, ".outTag"}, 64'(tg), 64'(f.tag));
      check({nm, ".illegal"}, 64'(il), 64'(f.ill));
    end
  endtask

  task automatic modelStep(input bit is64, input logic inV,
                           input logic outR,
                           input logic [24:0] ii,
                           input logic [2:0] s,
                           input logic [4:0] t);
    item_t it;
    int    sz;
    bit    acc;
    sz     = is64 ? q64.size() : q32.size();
    it.ill = (s == 3'b111);
    it.imm = it.ill ? 64'd0 : refImm(ii, s, is64);
    it.tag = t;
    acc    = inV && (sz < 2);
    if (is64) begin
      if (outR && sz > 0) void'(q64.pop_front());
      if (acc) q64.push_back(it);
      if (acc && it.ill && m64 < 255) m64++;
    end else begin
      if (outR && sz > 0) void'(q32.pop_front());
      if (acc) q32.push_back(it);
      if (acc && it.ill && m32 < 255) m32++;
    end
  endtask

  vec_t        vecs[13];
  int          nIll;
  logic        rv;
  logic        rr;
  logic [24:0] ri;
  logic [2:0]  rs;
  logic [4:0]  rt;

  initial begin
    vecs[0]  = '{0, 25'h1FFE001, 3'b000, 5'd3,
                 64'hFFFF_FFFF, 0};
    vecs[1]  = '{0, 25'h1FC001D, 3'b101, 5'd4,
                 64'hFFFF_FFFC, 0};
    vecs[2]  = '{0, 25'h0002000, 3'b110, 5'd5,
                 64'h0000_0800, 0};
    vecs[3]  = '{0, 25'h1FC0002, 3'b001, 5'd6,
                 64'hFFFF_FFE2, 0};
    vecs[4]  = '{1, 25'h1000001, 3'b010, 5'd7,
                 64'hFFFF_FFFF_8000_0000, 0};
    vecs[5]  = '{1, 25'h0046000, 3'b011, 5'd8,
                 64'h23, 0};
    vecs[6]  = '{0, 25'h007E000, 3'b011, 5'd9,
                 64'h1F, 0};
    vecs[7]  = '{1, 25'h007E000, 3'b011, 5'd10,
                 64'h3F, 0};
    vecs[8]  = '{0, 25'h0001F00, 3'b100, 5'd11,
                 64'h1F, 0};
    vecs[9]  = '{0, 25'h1234567, 3'b111, 5'd12,
                 64'h0, 1};
    vecs[10] = '{0, 25'h1000001, 3'b010, 5'd13,
                 64'h8000_0000, 0};
    vecs[11] = '{1, 25'h1FFE001, 3'b000, 5'd14,
                 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[12] = '{1, 25'h1FC001D, 3'b101, 5'd15,
                 64'hFFFF_FFFF_FFFF_FFFC, 0};

    rst = 1'b1;
    drv32(0, 0, 0, 0, 0);
    drv64(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst.inReady32", 64'(b32.InReady), 64'd0);
    check("rst.outValid32", 64'(b32.OutValid), 64'd0);
    check("rst.immExt32", 64'(b32.ImmExt), 64'd0);
    check("rst.outTag32", 64'(b32.OutTag), 64'd0);
    check("rst.illegal32", 64'(b32.IllegalSrc), 64'd0);
    check("rst.errCnt32", 64'(err32), 64'd0);
    check("rst.inReady64", 64'(b64.InReady), 64'd0);
    check("rst.outValid64", 64'(b64.OutValid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel.inReady32", 64'(b32.InReady), 64'd1);
    check("rel.inReady64", 64'(b64.InReady), 64'd1);

    nIll = 0;
    for (int k = 0; k < 13; k++) begin
      if (vecs[k].is64)
        drv64(1, vecs[k].src, vecs[k].imm, vecs[k].tag, 1);
      else
        drv32(1, vecs[k].src, vecs[k].imm, vecs[k].tag, 1);
      if (!vecs[k].is64 && vecs[k].ill) nIll++;
      @(negedge clk);
      if (vecs[k].is64) begin
        check($sformatf("vec%0d.valid", k),
              64'(b64.OutValid), 64'd1);
        check($sformatf("vec%0d.imm", k),
              b64.ImmExt, vecs[k].exp);
        check($sformatf("vec%0d.tag", k),
              64'(b64.OutTag), 64'(vecs[k].tag));
        check($sformatf("vec%0d.ill", k),
              64'(b64.IllegalSrc), 64'(vecs[k].ill));
      end else begin
        check($sformatf("vec%0d.valid", k),
              64'(b32.OutValid), 64'd1);
        check($sformatf("vec%0d.imm", k),
              64'(b32.ImmExt), vecs[k].exp);
        check($sformatf("vec%0d.tag", k),
              64'(b32.OutTag), 64'(vecs[k].tag));
        check($sformatf("vec%0d.ill", k),
              64'(b32.IllegalSrc), 64'(vecs[k].ill));
      end
      drv32(0, 0, 0, 0, 1);
      drv64(0, 0, 0, 0, 1);
    end
    check("tbl.errCnt32", 64'(err32), 64'(nIll));
    check("tbl.errCnt64", 64'(err64), 64'd0);

    // Back-pressure: tags 1,2,3 with a stalled sink
    @(negedge clk);
    drv32(1, 3'b000, 25'h1FFE001, 5'd1, 0);
    @(negedge clk);
    check("bp.inReadyA", 64'(b32.InReady), 64'd1);
    drv32(1, 3'b000, 25'h1FFE001, 5'd2, 0);
    @(negedge clk);
    drv32(1, 3'b000, 25'h1FFE001, 5'd3, 0);
    check("bp.inReadyB", 64'(b32.InReady), 64'd0);
    check("bp.tagHeld", 64'(b32.OutTag), 64'd1);
    @(negedge clk);
    check("bp.inReadyC", 64'(b32.InReady), 64'd0);
    check("bp.tagStall", 64'(b32.OutTag), 64'd1);
    b32.OutReady = 1'b1;
    @(negedge clk);
    check("bp.valid2", 64'(b32.OutValid), 64'd1);
    check("bp.tag2", 64'(b32.OutTag), 64'd2);
    check("bp.inReadyD", 64'(b32.InReady), 64'd1);
    @(negedge clk);
    b32.InValid = 1'b0;
    check("bp.valid3", 64'(b32.OutValid), 64'd1);
    check("bp.tag3", 64'(b32.OutTag), 64'd3);
    @(negedge clk);
    check("bp.empty", 64'(b32.OutValid), 64'd0);

    // Reset with the skid register full and ErrCnt=5
    pulseRst();
    for (int k = 0; k < 5; k++) begin
      drv32(1, 3'b111, 25'($urandom), 5'(20 + k), 1);
      @(negedge clk);
    end
    drv32(1, 3'b000, 25'h1FFE001, 5'd10, 0);
    @(negedge clk);
    drv32(0, 0, 0, 0, 0);
    check("rs.skidFull", 64'(b32.InReady), 64'd0);
    check("rs.errCnt5", 64'(err32), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    check("rs.inReadyRst", 64'(b32.InReady), 64'd0);
    check("rs.outValid", 64'(b32.OutValid), 64'd0);
    check("rs.errCnt", 64'(err32), 64'd0);
    check("rs.immExt", 64'(b32.ImmExt), 64'd0);
    check("rs.outTag", 64'(b32.OutTag), 64'd0);
    check("rs.illegal", 64'(b32.IllegalSrc), 64'd0);
    rst = 1'b0;
    b32.OutReady = 1'b1;
    @(negedge clk);
    check("rs.inReadyRel", 64'(b32.InReady), 64'd1);
    check("rs.noStale1", 64'(b32.OutValid), 64'd0);
    @(negedge clk);
    check("rs.noStale2", 64'(b32.OutValid), 64'd0);

    // Saturation of the illegal-select counter
    for (int k = 0; k < 300; k++) begin
      drv32(1, 3'b111, 25'($urandom), 5'(k), 1);
      if (k == 254)
        check("sat.at254", 64'(err32), 64'd254);
      if (k == 255)
        check("sat.at255", 64'(err32), 64'd255);
      @(negedge clk);
    end
    drv32(0, 0, 0, 0, 1);
    check("sat.held", 64'(err32), 64'd255);
    check("sat.imm", 64'(b32.ImmExt), 64'd0);
    check("sat.ill", 64'(b32.IllegalSrc), 64'd1);

    // Random traffic on both widths against the queue model
    pulseRst();
    q32.delete();
    q64.delete();
    m32 = 0;
    m64 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      observe(0, "r32");
      observe(1, "r64");
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      ri = 25'($urandom);
      rs = 3'($urandom_range(0, 7));
      rt = 5'($urandom);
      drv32(rv, rs, ri, rt, rr);
      modelStep(0, rv, rr, ri, rs, rt);
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      ri = 25'($urandom);
      rs = 3'($urandom_range(0, 7));
      rt = 5'($urandom);
      drv64(rv, rs, ri, rt, rr);
      modelStep(1, rv, rr, ri, rs, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
